// File: rtl/bin_to_digits.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) feeding the seven-segment scan controller.
// Optional macro LEADING_ZERO_BLANK_EN switches the output to raw active-low segments with leading-zero blanking.
module bin_to_digits #(
  parameter int unsigned C_NUM_DIGITS = 4,
  parameter int unsigned C_BIN_WIDTH  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [C_BIN_WIDTH-1:0]    bin_in,
  input  logic [C_NUM_DIGITS-1:0]   dp_mask,
  output logic [C_NUM_DIGITS*8-1:0] digits,
  output logic                      mode,
  output logic                      done,
  output logic                      overflow
);

  localparam int unsigned BCD_W = 4 * C_NUM_DIGITS;
  localparam int unsigned DIG_W = 8 * C_NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(C_BIN_WIDTH + 1);
  localparam int unsigned CMP_W = 64;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [CMP_W-1:0] LIMIT = pow10(C_NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [C_BIN_WIDTH-1:0]    shreg;
  logic [C_NUM_DIGITS-1:0]   mask_q;
  logic                      ovf_q;
  logic [BCD_W-1:0]          bcd;
  logic [BCD_W-1:0]          bcd_adj;
  logic [CNT_W-1:0]          cnt;
  logic                      accept;
  logic                      ovf_in;
  logic [DIG_W-1:0]          digits_nxt;
  logic [3:0]                nib;

  assign accept = in_valid && in_ready && (state == IDLE);
  assign ovf_in = (CMP_W'(bin_in) >= LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: nibbles >= 5 get +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < C_NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic       seen_nz;
  logic [6:0] seg;

  // Segment encode, walking from the most significant digit so leading zeros blank.
  // On overflow every nibble is 9, so no digit is ever blanked.
  always_comb begin
    digits_nxt = '0;
    seen_nz    = 1'b0;
    nib        = 4'h0;
    seg        = 7'h7F;
    for (int i = int'(C_NUM_DIGITS) - 1; i >= 0; i--) begin
      nib     = ovf_q ? 4'h9 : bcd[4*i +: 4];
      seen_nz = seen_nz | (nib != 4'h0);
      if (!seen_nz && (i != 0)) begin
        seg = 7'h7F;
      end else begin
        seg = seg7(nib);
      end
      digits_nxt[8*i +: 8] = {~mask_q[i], seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
    end else if (state == LOAD) begin
      mode <= 1'b1;
    end
  end
`else
  // Nibble mode: byte = {~dp, 3'b000, bcd}
  always_comb begin
    digits_nxt = '0;
    nib        = 4'h0;
    for (int unsigned i = 0; i < C_NUM_DIGITS; i++) begin
      nib                  = ovf_q ? 4'h9 : bcd[4*i +: 4];
      digits_nxt[8*i +: 8] = {~mask_q[i], 3'b000, nib};
    end
  end

  assign mode = 1'b0;
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= {C_NUM_DIGITS{8'h80}};
      shreg    <= '0;
      mask_q   <= '0;
      ovf_q    <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      done     <= 1'b0;
      in_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= bin_in;
            mask_q <= dp_mask;
            ovf_q  <= ovf_in;
            bcd    <= '0;
            cnt    <= CNT_W'(C_BIN_WIDTH);
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
          cnt          <= cnt - CNT_W'(1);
        end
        LOAD: begin
          digits   <= digits_nxt;
          overflow <= ovf_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_digits.sv
// Self-checking bench for bin_to_digits: directed and random values against an arithmetic reference model.
module tb_bin_to_digits;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 14;
  localparam int          LAT = W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     bin_in;
  logic [N-1:0]     dp_mask;
  logic [8*N-1:0]   digits;
  logic             mode;
  logic             done;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  logic [8*N-1:0] rst_digits;

  bin_to_digits #(.C_NUM_DIGITS(N), .C_BIN_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_in   (bin_in),
    .dp_mask  (dp_mask),
    .digits   (digits),
    .mode     (mode),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
  localparam logic EXP_MODE = 1'b1;
`else
  localparam logic EXP_MODE = 1'b0;
`endif

  function automatic longint unsigned p10(input int n);
    longint unsigned p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic exp_ovf(input longint unsigned v);
    return v >= p10(N);
  endfunction

  // Decimal digits by repeated division; saturate to all nines on overflow
  function automatic logic [8*N-1:0] exp_digits(input longint unsigned v, input logic [N-1:0] m);
    logic [8*N-1:0]  w;
    longint unsigned rest;
    int              d;
    logic            ovf;
    w    = '0;
    ovf  = exp_ovf(v);
    rest = v;
    for (int i = 0; i < int'(N); i++) begin
      d    = ovf ? 9 : int'(rest % 10);
      rest = rest / 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (!ovf && i > 0 && v < p10(i)) w[8*i +: 8] = {~m[i], 7'h7F};
      else                             w[8*i +: 8] = {~m[i], SEG[d]};
`else
      w[8*i +: 8] = {~m[i], 3'b000, 4'(d)};
`endif
    end
    return w;
  endfunction

  task automatic accept_value(input logic [W-1:0] v, input logic [N-1:0] m, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bin_in   = v;
    dp_mask  = m;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (mode !== 1'b0) begin failures++; $display("FAIL reset_mode got %b want 0", mode); end
    checks++; if (digits !== rst_digits) begin failures++; $display("FAIL reset_digits got %h want %h", digits, rst_digits); end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    bit ok;
    int lat;
    logic [8*N-1:0] e;
    accept_value(W'(1234), 4'b0000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nominal_accept got 0 want 1"); end
    wait_done(lat);
    e = exp_digits(1234, 4'b0000);
    checks++; if (lat != LAT) begin failures++; $display("FAIL nominal_latency got %0d want %0d", lat, LAT); end
    checks++; if (digits !== e) begin failures++; $display("FAIL nominal_digits got %h want %h", digits, e); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL nominal_overflow got %b want 0", overflow); end
    checks++; if (mode !== EXP_MODE) begin failures++; $display("FAIL nominal_mode got %b want %b", mode, EXP_MODE); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL nominal_done_width got %b want 0", done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nominal_ready_back got %b want 1", in_ready); end
    checks++; if (digits !== e) begin failures++; $display("FAIL nominal_hold got %h want %h", digits, e); end
  endtask

  task automatic test_dp;
    bit ok;
    int lat;
    logic [8*N-1:0] e;
    accept_value(W'(56), 4'b0100, ok);
    wait_done(lat);
    e = exp_digits(56, 4'b0100);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL dp_latency got %0d want %0d", lat, LAT); end
    checks++; if (digits !== e) begin failures++; $display("FAIL dp_digits got %h want %h", digits, e); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] vals  [6] = '{W'(12000), W'(7), W'(9999), W'(10000), W'(16383), W'(0)};
    logic [N-1:0] masks [6] = '{4'b0000, 4'b0000, 4'b1001, 4'b0010, 4'b1111, 4'b0000};
    bit ok;
    int lat;
    logic [8*N-1:0] e;
    for (int t = 0; t < 6; t++) begin
      accept_value(vals[t], masks[t], ok);
      wait_done(lat);
      e = exp_digits(64'(vals[t]), masks[t]);
      checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL ovf_latency[%0d] got %0d want %0d", vals[t], lat, LAT); end
      checks++; if (digits !== e) begin failures++; $display("FAIL ovf_digits[%0d] got %h want %h", vals[t], digits, e); end
      checks++; if (overflow !== exp_ovf(64'(vals[t]))) begin failures++; $display("FAIL ovf_flag[%0d] got %b want %b", vals[t], overflow, exp_ovf(64'(vals[t]))); end
    end
  endtask

  task automatic test_random;
    bit ok;
    int lat;
    int changes;
    logic [W-1:0]   v;
    logic [N-1:0]   m;
    logic [8*N-1:0] prev;
    logic [8*N-1:0] e;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 0) v = W'($urandom_range(0, (1 << W) - 1));
      else                           v = W'($urandom_range(9990, 10010));
      m       = N'($urandom);
      prev    = digits;
      changes = 0;
      accept_value(v, m, ok);
      lat = -1;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (done) begin
          lat = c;
          break;
        end
        if (digits !== prev) changes++;
      end
      e = exp_digits(64'(v), m);
      checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL rand_latency[%0d] got %0d want %0d", v, lat, LAT); end
      checks++; if (changes != 0) begin failures++; $display("FAIL rand_stable[%0d] got %0d early changes want 0", v, changes); end
      checks++; if (digits !== e) begin failures++; $display("FAIL rand_digits[%0d] got %h want %h", v, digits, e); end
      checks++; if (overflow !== exp_ovf(64'(v))) begin failures++; $display("FAIL rand_overflow[%0d] got %b want %b", v, overflow, exp_ovf(64'(v))); end
      checks++; if (mode !== EXP_MODE) begin failures++; $display("FAIL rand_mode[%0d] got %b want %b", v, mode, EXP_MODE); end
    end
  endtask

  task automatic test_back_to_back;
    int low_cnt;
    int early;
    int extra;
    int lat;
    bit ok;
    @(negedge clk);
    bin_in   = W'(5);
    dp_mask  = '0;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bin_in = W'(9);
    low_cnt = 0;
    early   = 0;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      if (!in_ready) low_cnt++;
      if (done) early++;
    end
    checks++; if (!ok || low_cnt != LAT || early != 0) begin failures++; $display("FAIL b2b_busy got low=%0d early=%0d want low=%0d early=0", low_cnt, early, LAT); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_done got done=%b ready=%b want 1 1", done, in_ready); end
    checks++; if (digits !== exp_digits(5, '0)) begin failures++; $display("FAIL b2b_first_digits got %h want %h", digits, exp_digits(5, '0)); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got ready=%b want 0", in_ready); end
    wait_done(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
    checks++; if (digits !== exp_digits(9, '0)) begin failures++; $display("FAIL b2b_second_digits got %h want %h", digits, exp_digits(9, '0)); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL b2b_duplicate got %0d extra done pulses want 0", extra); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int dones;
    accept_value(W'(4321), 4'b0011, ok);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (!ok || digits !== rst_digits) begin failures++; $display("FAIL midrst_digits got %h want %h", digits, rst_digits); end
    checks++; if (in_ready !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL midrst_ready got ready=%b ovf=%b want 1 0", in_ready, overflow); end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL midrst_done got %0d pulses want 0", dones); end
    checks++; if (in_ready !== 1'b1 || digits !== rst_digits) begin failures++; $display("FAIL midrst_idle got ready=%b digits=%h want 1 %h", in_ready, digits, rst_digits); end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    bin_in     = '0;
    dp_mask    = '0;
    rst_digits = {N{8'h80}};
    test_reset();
    test_nominal();
    test_dp();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
